mm_job_sequencer: RTL and testbench

Top-level job controller for the systolic matrix multiplier. It accepts one job descriptor (m, n, p) per handshake and checks it against the array and buffer geometry. It then sequences the A/B operand address generators, the array drain, and the result writeback, and reports completion status. It sits between the configuration/register module and the address generators, array and result writer.

---
 rtl/mm_pkg.sv | 28 ++
 rtl/mm_cfg_check.sv | 38 +++
 rtl/mm_job_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mm_job_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-multiply job sequencer.
package mm_pkg;

   localparam int DIM_W  = 16;
   localparam int PERF_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_START,
      ST_STREAM,
      ST_DRAIN,
      ST_WB,
      ST_FINISH
   } mm_state_e;

   typedef enum logic [1:0] {
      MM_OK      = 2'b00,
      MM_CFG_ERR = 2'b01,
      MM_ABORT   = 2'b10
   } mm_status_e;

   // Cycles for the last partial sums to leave the array after streaming ends.
   function automatic int unsigned drain_len(input int unsigned h, input int unsigned w);
      return h + w - 1;
   endfunction

endpackage

// File: rtl/mm_cfg_check.sv
// Combinational legality check of a job descriptor against array and buffer geometry.
module mm_cfg_check
   import mm_pkg::*;
#(
   parameter int ARRAY_HEIGHT         = 4,
   parameter int ARRAY_WIDTH          = 4,
   parameter int BUFFER_ADDRESS_WIDTH = 10
) (
   input  logic [DIM_W-1:0] m,
   input  logic [DIM_W-1:0] n,
   input  logic [DIM_W-1:0] p,
   output logic             cfg_err
);

   localparam int          HB        = $clog2(ARRAY_HEIGHT);
   localparam int          WB        = $clog2(ARRAY_WIDTH);
   localparam logic [32:0] BUF_DEPTH = 33'd1 << BUFFER_ADDRESS_WIDTH;

   logic [31:0] prod_mn;
   logic [31:0] prod_np;
   logic        zero_dim;
   logic        m_misaligned;
   logic        p_misaligned;
   logic        a_too_big;
   logic        b_too_big;

   // 16x16 products fit exactly in 32 bits; compare at 33 so depth 2**32 is still safe.
   assign prod_mn      = 32'(m) * 32'(n);
   assign prod_np      = 32'(n) * 32'(p);
   assign zero_dim     = (m == '0) || (n == '0) || (p == '0);
   assign m_misaligned = (m[HB-1:0] != '0);
   assign p_misaligned = (p[WB-1:0] != '0);
   assign a_too_big    = ({1'b0, prod_mn} > BUF_DEPTH);
   assign b_too_big    = ({1'b0, prod_np} > BUF_DEPTH);

   assign cfg_err = zero_dim || m_misaligned || p_misaligned || a_too_big || b_too_big;

endmodule

// File: rtl/mm_job_sequencer.sv
// Job controller for the systolic matrix multiplier: accepts a descriptor, validates it,
// then sequences operand generation, array drain and result writeback.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a descriptor
// CHECK     | latched descriptor is checked for legality
// START     | one-cycle start pulse to the A/B address generators
// STREAM    | array computing; waiting for both generator done pulses
// DRAIN     | array computing while the last results flush out
// WB        | result writer started; waiting for its done pulse
// FINISH    | one-cycle done pulse with final status
module mm_job_sequencer
   import mm_pkg::*;
#(
   parameter int ARRAY_HEIGHT         = 4,
   parameter int ARRAY_WIDTH          = 4,
   parameter int BUFFER_ADDRESS_WIDTH = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DIM_W-1:0]  cfg_m,
   input  logic [DIM_W-1:0]  cfg_n,
   input  logic [DIM_W-1:0]  cfg_p,
   input  logic              abort,
   output logic [DIM_W-1:0]  job_m,
   output logic [DIM_W-1:0]  job_n,
   output logic [DIM_W-1:0]  job_p,
   output logic              gen_start,
   input  logic              a_done,
   input  logic              b_done,
   output logic              stream_en,
   output logic              wb_start,
   input  logic              wb_done,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [PERF_W-1:0] perf_cycles
);

   localparam logic [15:0] DRAIN_LEN = 16'(drain_len(ARRAY_HEIGHT, ARRAY_WIDTH));

   mm_state_e  state, state_nxt;
   mm_status_e status_q, status_nxt;
   logic       cfg_err;
   logic       a_seen, b_seen;
   logic       wb_first;
   logic [15:0] drain_cnt;
   logic       accept;
   logic       counting;

   mm_cfg_check #(
      .ARRAY_HEIGHT         (ARRAY_HEIGHT),
      .ARRAY_WIDTH          (ARRAY_WIDTH),
      .BUFFER_ADDRESS_WIDTH (BUFFER_ADDRESS_WIDTH)
   ) u_cfg_check (
      .m       (job_m),
      .n       (job_n),
      .p       (job_p),
      .cfg_err (cfg_err)
   );

   assign accept   = (state == ST_IDLE) && cfg_valid;
   assign counting = (state == ST_START) || (state == ST_STREAM) ||
                     (state == ST_DRAIN) || (state == ST_WB);

   always_comb begin
      state_nxt  = state;
      status_nxt = status_q;
      case (state)
         ST_IDLE: begin
            if (cfg_valid) begin
               state_nxt  = ST_CHECK;
               status_nxt = MM_OK;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_nxt  = ST_FINISH;
               status_nxt = MM_ABORT;
            end else if (cfg_err) begin
               state_nxt  = ST_FINISH;
               status_nxt = MM_CFG_ERR;
            end else begin
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (abort) begin
               state_nxt  = ST_FINISH;
               status_nxt = MM_ABORT;
            end else begin
               state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (abort) begin
               state_nxt  = ST_FINISH;
               status_nxt = MM_ABORT;
            end else if ((a_seen || a_done) && (b_seen || b_done)) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_nxt  = ST_FINISH;
               status_nxt = MM_ABORT;
            end else if (drain_cnt == 16'd1) begin
               state_nxt = ST_WB;
            end
         end
         ST_WB: begin
            if (abort) begin
               state_nxt  = ST_FINISH;
               status_nxt = MM_ABORT;
            end else if (wb_done) begin
               state_nxt  = ST_FINISH;
               status_nxt = MM_OK;
            end
         end
         ST_FINISH: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         status_q <= MM_OK;
      end else begin
         state    <= state_nxt;
         status_q <= status_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         job_m       <= '0;
         job_n       <= '0;
         job_p       <= '0;
         perf_cycles <= '0;
      end else if (accept) begin
         job_m       <= cfg_m;
         job_n       <= cfg_n;
         job_p       <= cfg_p;
         perf_cycles <= '0;
      end else if (counting && (perf_cycles != '1)) begin
         perf_cycles <= perf_cycles + 1'b1;
      end
   end

   // Done flags are cleared in START so a pulse in the first STREAM cycle is kept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_seen <= 1'b0;
         b_seen <= 1'b0;
      end else if (state == ST_START) begin
         a_seen <= 1'b0;
         b_seen <= 1'b0;
      end else if (state == ST_STREAM) begin
         a_seen <= a_seen || a_done;
         b_seen <= b_seen || b_done;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drain_cnt <= '0;
         wb_first  <= 1'b0;
      end else begin
         if ((state_nxt == ST_DRAIN) && (state != ST_DRAIN))
            drain_cnt <= DRAIN_LEN;
         else if ((state == ST_DRAIN) && (drain_cnt != '0))
            drain_cnt <= drain_cnt - 16'd1;
         wb_first <= (state_nxt == ST_WB) && (state != ST_WB);
      end
   end

   assign cfg_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FINISH);
   assign gen_start = (state == ST_START);
   assign stream_en = (state == ST_STREAM) || (state == ST_DRAIN);
   assign wb_start  = (state == ST_WB) && wb_first;
   assign status    = status_q;

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Directed bench for mm_job_sequencer: descriptor table plus hand-timed job sequences.
module tb_mm_job_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_valid, cfg_ready;
   logic [15:0] cfg_m, cfg_n, cfg_p;
   logic        abort;
   logic [15:0] job_m, job_n, job_p;
   logic        gen_start, a_done, b_done, stream_en, wb_start, wb_done;
   logic        busy, done;
   logic [1:0]  status;
   logic [31:0] perf_cycles;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] m;
      logic [15:0] n;
      logic [15:0] p;
      logic        err;
   } vec_t;

   vec_t vecs[15];

   mm_job_sequencer #(
      .ARRAY_HEIGHT(4), .ARRAY_WIDTH(4), .BUFFER_ADDRESS_WIDTH(10)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p),
      .abort(abort),
      .job_m(job_m), .job_n(job_n), .job_p(job_p),
      .gen_start(gen_start), .a_done(a_done), .b_done(b_done),
      .stream_en(stream_en), .wb_start(wb_start), .wb_done(wb_done),
      .busy(busy), .done(done), .status(status), .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input logic [15:0] m, input logic [15:0] n, input logic [15:0] p);
      cfg_m = m;
      cfg_n = n;
      cfg_p = p;
   endtask

   // Entered in a STREAM cycle; finishes the job normally and checks status.
   task automatic complete_job(input string tag, input logic [31:0] exp_perf);
      int seen = 0;
      a_done = 1'b1;
      b_done = 1'b1;
      step();
      a_done = 1'b0;
      b_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (wb_start) begin
            seen = 1;
            break;
         end
         step();
      end
      chk({tag, "_wb_start_seen"}, 32'(seen), 32'd1);
      wb_done = 1'b1;
      step();
      wb_done = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_status"}, 32'(status), 32'd0);
      chk({tag, "_perf"}, perf_cycles, exp_perf);
      step();
   endtask

   initial begin
      vecs[0]  = '{16'd4,     16'd4,     16'd4,    1'b0};
      vecs[1]  = '{16'd6,     16'd4,     16'd4,    1'b1};
      vecs[2]  = '{16'd32,    16'd64,    16'd4,    1'b1};
      vecs[3]  = '{16'd0,     16'd4,     16'd4,    1'b1};
      vecs[4]  = '{16'd4,     16'd0,     16'd4,    1'b1};
      vecs[5]  = '{16'd4,     16'd4,     16'd0,    1'b1};
      vecs[6]  = '{16'd4,     16'd4,     16'd6,    1'b1};
      vecs[7]  = '{16'd32,    16'd32,    16'd4,    1'b0};
      vecs[8]  = '{16'd4,     16'd256,   16'd4,    1'b0};
      vecs[9]  = '{16'd4,     16'd257,   16'd4,    1'b1};
      vecs[10] = '{16'd8,     16'd16,    16'd64,   1'b0};
      vecs[11] = '{16'd8,     16'd2,     16'd512,  1'b0};
      vecs[12] = '{16'd4,     16'd1,     16'd1028, 1'b1};
      vecs[13] = '{16'd65532, 16'd65535, 16'd4,    1'b1};
      vecs[14] = '{16'd8,     16'd1,     16'd4,    1'b0};

      reset_n   = 1'b0;
      cfg_valid = 1'b0;
      abort     = 1'b0;
      a_done    = 1'b0;
      b_done    = 1'b0;
      wb_done   = 1'b0;
      set_cfg(16'd0, 16'd0, 16'd0);
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pulses", {29'd0, gen_start, wb_start, done}, 32'd0);
      chk("rst_stream_en", 32'(stream_en), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_job", {job_m, job_n | job_p}, 32'd0);
      chk("rst_perf", perf_cycles, 32'd0);

      // Exact-timing job: accept at edge T, both done pulses at S = T+4.
      set_cfg(16'd4, 16'd4, 16'd4);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      chk("t1_check_busy", {30'd0, busy, cfg_ready}, 32'd2);
      chk("t1_job_m", 32'(job_m), 32'd4);
      chk("t1_check_no_gen", 32'(gen_start), 32'd0);
      step();
      chk("t1_gen_start", 32'(gen_start), 32'd1);
      step();
      chk("t1_gen_pulse_one", 32'(gen_start), 32'd0);
      chk("t1_stream_en", 32'(stream_en), 32'd1);
      step();
      a_done = 1'b1;
      b_done = 1'b1;
      step();
      a_done = 1'b0;
      b_done = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("t1_drain_stream_en", 32'(stream_en), 32'd1);
         chk("t1_drain_no_wb", 32'(wb_start), 32'd0);
         step();
      end
      chk("t1_wb_start", 32'(wb_start), 32'd1);
      chk("t1_wb_stream_off", 32'(stream_en), 32'd0);
      step();
      chk("t1_wb_pulse_one", 32'(wb_start), 32'd0);
      step();
      step();
      wb_done = 1'b1;
      step();
      wb_done = 1'b0;
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_status", 32'(status), 32'd0);
      chk("t1_perf", perf_cycles, 32'd14);
      step();
      chk("t1_idle_ready", {30'd0, cfg_ready, done}, 32'd2);
      chk("t1_perf_held", perf_cycles, 32'd14);

      // Descriptor table
      for (int v = 0; v < 15; v++) begin
         set_cfg(vecs[v].m, vecs[v].n, vecs[v].p);
         cfg_valid = 1'b1;
         step();
         cfg_valid = 1'b0;
         chk($sformatf("vec%0d_job_p", v), 32'(job_p), 32'(vecs[v].p));
         step();
         if (vecs[v].err) begin
            chk($sformatf("vec%0d_err_done", v), 32'(done), 32'd1);
            chk($sformatf("vec%0d_err_status", v), 32'(status), 32'd1);
            chk($sformatf("vec%0d_err_no_gen", v), 32'(gen_start), 32'd0);
            step();
         end else begin
            chk($sformatf("vec%0d_gen_start", v), 32'(gen_start), 32'd1);
            step();
            complete_job($sformatf("vec%0d", v), 32'd10);
         end
      end

      // Late b_done, spurious wb_done in STREAM, wb_done together with wb_start.
      set_cfg(16'd4, 16'd4, 16'd4);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      step();
      a_done  = 1'b1;
      wb_done = 1'b1;
      step();
      a_done  = 1'b0;
      wb_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("late_wait_no_wb", {30'd0, wb_start, done}, 32'd0);
         chk("late_wait_stream", 32'(stream_en), 32'd1);
         step();
      end
      b_done = 1'b1;
      step();
      b_done = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk("late_drain_no_wb", 32'(wb_start), 32'd0);
         step();
      end
      chk("late_wb_start", 32'(wb_start), 32'd1);
      wb_done = 1'b1;
      step();
      wb_done = 1'b0;
      chk("late_done", 32'(done), 32'd1);
      chk("late_status", 32'(status), 32'd0);
      chk("late_perf", perf_cycles, 32'd15);
      step();

      // Abort in the third STREAM cycle.
      set_cfg(16'd4, 16'd4, 16'd4);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      step();
      step();
      step();
      abort = 1'b1;
      chk("abort_stream_before", 32'(stream_en), 32'd1);
      step();
      abort = 1'b0;
      chk("abort_stream_off", 32'(stream_en), 32'd0);
      chk("abort_done", 32'(done), 32'd1);
      chk("abort_status", 32'(status), 32'd2);
      chk("abort_perf", perf_cycles, 32'd4);
      step();
      chk("abort_idle_no_wb", {30'd0, wb_start, cfg_ready}, 32'd1);
      chk("abort_status_held", 32'(status), 32'd2);

      // cfg_valid held across an error job and a following legal job.
      set_cfg(16'd6, 16'd4, 16'd4);
      cfg_valid = 1'b1;
      step();
      set_cfg(16'd4, 16'd4, 16'd4);
      chk("b2b_busy", 32'(busy), 32'd1);
      step();
      chk("b2b_done_err", {30'd0, status}, 32'd1);
      chk("b2b_done", 32'(done), 32'd1);
      step();
      chk("b2b_idle_ready", 32'(cfg_ready), 32'd1);
      chk("b2b_job_m_old", 32'(job_m), 32'd6);
      step();
      cfg_valid = 1'b0;
      chk("b2b_job_m_new", 32'(job_m), 32'd4);
      chk("b2b_status_cleared", 32'(status), 32'd0);
      step();
      chk("b2b_gen_start", 32'(gen_start), 32'd1);
      step();
      complete_job("b2b", 32'd10);

      // Asynchronous reset while in WB.
      set_cfg(16'd8, 16'd8, 16'd8);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      step();
      a_done = 1'b1;
      b_done = 1'b1;
      step();
      a_done = 1'b0;
      b_done = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("rwb_wb_start", 32'(wb_start), 32'd1);
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("rwb_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rwb_busy", 32'(busy), 32'd0);
      chk("rwb_outs", {28'd0, gen_start, wb_start, done, stream_en}, 32'd0);
      chk("rwb_status", 32'(status), 32'd0);
      chk("rwb_job", {job_m, job_n | job_p}, 32'd0);
      chk("rwb_perf", perf_cycles, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      chk("rwb_after_release", {30'd0, cfg_ready, busy}, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule
